// File: rtl/score_keeper.sv
// Four-digit packed-BCD score counter with session best and RUN/OVER control.
// Feeds the seven-segment multiplexer from the game FSM strobes.
module score_keeper #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        pass_in,
  input  logic        game_over,
  output logic [15:0] score,
  output logic [15:0] best,
  output logic        new_best,
  output logic        overflow,
  output logic        score_upd,
  output logic        over
);

  typedef enum logic {RUN, OVER} state_t;

  state_t      state;
  logic        pass_q;
  logic        go_q;
  logic        inc_ev;
  logic        go_ev;
  logic        at_max;
  logic        carry;
  logic [15:0] inc_val;

  assign inc_ev = pass_in & ~pass_q;
  assign go_ev  = game_over & ~go_q;
  assign at_max = (score == 16'h9999);

  // Ripple the BCD carry from units upward.
  always_comb begin
    inc_val = score;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pass_q    <= 1'b0;
      go_q      <= 1'b0;
      score     <= 16'h0000;
      best      <= 16'h0000;
      new_best  <= 1'b0;
      overflow  <= 1'b0;
      score_upd <= 1'b0;
      over      <= 1'b0;
    end else begin
      pass_q    <= pass_in;
      go_q      <= game_over;
      score_upd <= 1'b0;
      if (clr) begin
        state     <= RUN;
        over      <= 1'b0;
        score     <= 16'h0000;
        overflow  <= 1'b0;
        new_best  <= 1'b0;
        score_upd <= |score;
      end else begin
        unique case (state)
          RUN: begin
            if (go_ev) begin
              state <= OVER;
              over  <= 1'b1;
              if (score > best) begin
                best     <= score;
                new_best <= 1'b1;
              end else begin
                new_best <= 1'b0;
              end
            end else if (inc_ev) begin
              if (at_max) begin
                overflow <= 1'b1;
                if (!SATURATE) begin
                  score     <= 16'h0000;
                  score_upd <= 1'b1;
                end
              end else begin
                score     <= inc_val;
                score_upd <= 1'b1;
              end
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: saturating and wrapping instances
// driven in parallel, score_upd pulses popped against queued scores.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        pass_in;
  logic        game_over;

  logic [15:0] s_score, s_best, w_score, w_best;
  logic        s_nb, s_ovf, s_upd, s_over;
  logic        w_nb, w_ovf, w_upd, w_over;

  int errors = 0;
  int checks = 0;
  int s_pulses = 0;
  int ms = 0;
  int mw = 0;
  bit run = 1'b1;
  logic [15:0] qs[$];
  logic [15:0] qw[$];

  always #5 clk = ~clk;

  score_keeper #(.SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .pass_in(pass_in), .game_over(game_over),
    .score(s_score), .best(s_best), .new_best(s_nb),
    .overflow(s_ovf), .score_upd(s_upd), .over(s_over)
  );

  score_keeper #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .pass_in(pass_in), .game_over(game_over),
    .score(w_score), .best(w_best), .new_best(w_nb),
    .overflow(w_ovf), .score_upd(w_upd), .over(w_over)
  );

  function automatic logic [15:0] bcd(input int v);
    bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10),
           4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every score_upd pulse must match the oldest queued score.
  always @(negedge clk) begin
    if (rst_n && s_upd) begin
      s_pulses++;
      checks++;
      if (qs.size() == 0) begin
        errors++;
        $display("FAIL sat_upd: unexpected pulse score=%h", s_score);
      end else begin
        logic [15:0] e;
        e = qs.pop_front();
        if (s_score !== e) begin
          errors++;
          $display("FAIL sat_score: got %h expected %h", s_score, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_upd) begin
      checks++;
      if (qw.size() == 0) begin
        errors++;
        $display("FAIL wrap_upd: unexpected pulse score=%h", w_score);
      end else begin
        logic [15:0] e;
        e = qw.pop_front();
        if (w_score !== e) begin
          errors++;
          $display("FAIL wrap_score: got %h expected %h", w_score, e);
        end
      end
    end
  end

  task automatic model_inc();
    if (run) begin
      if (ms != 9999) begin
        ms++;
        qs.push_back(bcd(ms));
      end
      mw = (mw == 9999) ? 0 : mw + 1;
      qw.push_back(bcd(mw));
    end
  endtask

  task automatic pass_edge(input int hold);
    pass_in = 1'b1;
    model_inc();
    repeat (hold) @(negedge clk);
    pass_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic passes(input int n);
    for (int i = 0; i < n; i++) pass_edge(1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    if (ms != 0) qs.push_back(16'h0000);
    if (mw != 0) qw.push_back(16'h0000);
    ms = 0;
    mw = 0;
    run = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic go_edge();
    game_over = 1'b1;
    run = 1'b0;
    @(negedge clk);
    game_over = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    pass_in = 1'b0;
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_score", s_score, 16'h0000);
    chk("rst_best", s_best, 16'h0000);
    chk("rst_flags", {12'h0, s_nb, s_ovf, s_upd, s_over}, 16'h0000);
    chk("rst_wflags", {12'h0, w_nb, w_ovf, w_upd, w_over}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) pass_edge(3);
    chk("t1_score", s_score, 16'h0012);
    chk("t1_pulses", 16'(s_pulses), 16'd12);

    passes(87);
    chk("t2_0099", s_score, 16'h0099);
    passes(1);
    chk("t2_0100", s_score, 16'h0100);
    passes(899);
    chk("t2_0999", s_score, 16'h0999);
    passes(1);
    chk("t2_1000", w_score, 16'h1000);

    passes(8999);
    chk("t3_9999", s_score, 16'h9999);
    chk("t3_ovf0", {15'h0, s_ovf}, 16'h0000);
    passes(1);
    chk("t3_sat", s_score, 16'h9999);
    chk("t3_sat_ovf", {15'h0, s_ovf}, 16'h0001);
    chk("t3_wrap", w_score, 16'h0000);
    chk("t3_wrap_ovf", {15'h0, w_ovf}, 16'h0001);
    do_clr();
    @(negedge clk);
    chk("t3_clr_ovf", {14'h0, s_ovf, w_ovf}, 16'h0000);

    passes(42);
    go_edge();
    chk("t4_over", {14'h0, s_over, w_over}, 16'h0003);
    chk("t4_best", s_best, 16'h0042);
    chk("t4_nb", {14'h0, s_nb, w_nb}, 16'h0003);
    passes(3);
    chk("t4_frozen", s_score, 16'h0042);

    do_clr();
    chk("t5_score", s_score, 16'h0000);
    chk("t5_over", {15'h0, s_over}, 16'h0000);
    chk("t5_best", s_best, 16'h0042);
    passes(30);
    go_edge();
    chk("t5_score30", s_score, 16'h0030);
    chk("t5_best_kept", s_best, 16'h0042);
    chk("t5_nb", {15'h0, s_nb}, 16'h0000);

    rst_n = 1'b0;
    ms = 0;
    mw = 0;
    run = 1'b1;
    #1;
    chk("rst_mid_best", s_best, 16'h0000);
    chk("rst_mid_score", w_score, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    passes(7);
    pass_in = 1'b1;
    game_over = 1'b1;
    run = 1'b0;
    @(negedge clk);
    chk("t6_score", s_score, 16'h0007);
    chk("t6_best", s_best, 16'h0007);
    chk("t6_over", {15'h0, s_over}, 16'h0001);
    pass_in = 1'b0;
    game_over = 1'b0;
    @(negedge clk);
    game_over = 1'b1;
    do_clr();
    @(negedge clk);
    chk("t6_clr_score", s_score, 16'h0000);
    chk("t6_clr_over", {14'h0, s_over, w_over}, 16'h0000);
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    chk("q_empty", 16'(qs.size() + qw.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
